// File: rtl/nano_mem_pkg.sv
// Shared encodings, default widths and small helpers for the NanoRisc
// instruction/data memory arbiter.
package nano_mem_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_MEM_LATENCY  = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  // Wide enough for MEM_LATENCY and STARVE_LIMIT up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                              input logic [CNT_W-1:0] limit);
    return (value >= limit) ? limit : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/nano_arb_picker.sv
// Combinational grant select for the memory arbiter. NANO_ARB_ROUND_ROBIN_EN
// selects alternating round-robin; otherwise data wins unless fetch is starved.
module nano_arb_picker
  import nano_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             i_fetch_req,
  input  logic             i_data_req,
  input  logic [CNT_W-1:0] i_hist,
  output logic             o_grant_valid,
  output owner_t           o_grant_owner,
  output logic [CNT_W-1:0] o_next_hist
);

`ifdef NANO_ARB_ROUND_ROBIN_EN
  // The history register only ever holds the last owner (0 = fetch, 1 = data).
  owner_t w_lastOwner;
  assign w_lastOwner = (|i_hist) ? OWN_DATA : OWN_FETCH;

  always_comb begin
    o_grant_valid = i_fetch_req | i_data_req;
    o_grant_owner = OWN_FETCH;
    if (i_fetch_req && i_data_req)
      o_grant_owner = (w_lastOwner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    else if (i_data_req)
      o_grant_owner = OWN_DATA;
    o_next_hist = CNT_W'(o_grant_owner);
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // The history register is the starve counter: data grants won over a waiting fetch.
  logic w_starved;
  assign w_starved = i_fetch_req && (i_hist == LIMIT);

  always_comb begin
    o_grant_valid = i_fetch_req | i_data_req;
    o_grant_owner = OWN_FETCH;
    o_next_hist   = '0;
    if (i_data_req && !w_starved) begin
      o_grant_owner = OWN_DATA;
      if (i_fetch_req)
        o_next_hist = satInc(i_hist, LIMIT);
    end
  end
`endif

endmodule

// File: rtl/nano_mem_arbiter.sv
// Shares one single-port synchronous memory between NanoRisc fetch and load/store.
// Arbitration policy is chosen in nano_arb_picker via NANO_ARB_ROUND_ROBIN_EN.
module nano_mem_arbiter
  import nano_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_ack,
  output logic [DATA_W-1:0] o_fetch_data,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_ack,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  owner_t            r_owner;
  logic              r_latWe;
  logic [CNT_W-1:0]  r_latCnt;
  logic [CNT_W-1:0]  r_arbHist;

  logic              r_memEn;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_fetchAck;
  logic [DATA_W-1:0] r_fetchData;
  logic              r_dataAck;
  logic [DATA_W-1:0] r_dataRdata;
  logic              r_busy;

  logic              w_grantValid;
  owner_t            w_grantOwner;
  logic [CNT_W-1:0]  w_nextHist;
  logic              w_grant;
  logic              w_selWe;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;
  logic              w_lastBeat;

  nano_arb_picker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .i_fetch_req   (i_fetch_req),
    .i_data_req    (i_data_req),
    .i_hist        (r_arbHist),
    .o_grant_valid (w_grantValid),
    .o_grant_owner (w_grantOwner),
    .o_next_hist   (w_nextHist)
  );

  assign w_grant    = (r_state == ST_IDLE) && w_grantValid;
  assign w_selWe    = (w_grantOwner == OWN_DATA) ? i_data_we : 1'b0;
  assign w_selAddr  = (w_grantOwner == OWN_DATA) ? i_data_addr : i_fetch_addr;
  assign w_selWdata = (w_grantOwner == OWN_DATA && i_data_we) ? i_data_wdata : '0;
  assign w_lastBeat = (r_state == ST_WAIT) && (r_latCnt == CNT_W'(1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_grantValid) w_nextState = ST_ISSUE;
      ST_ISSUE: w_nextState = ST_WAIT;
      ST_WAIT:  if (w_lastBeat) w_nextState = ST_RESP;
      ST_RESP:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Owner, direction, arbitration history and the read-latency countdown.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_owner   <= OWN_FETCH;
      r_latWe   <= 1'b0;
      r_latCnt  <= '0;
      r_arbHist <= '0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_grantOwner;
        r_latWe   <= w_selWe;
        r_arbHist <= w_nextHist;
      end
      if (r_state == ST_ISSUE)
        r_latCnt <= CNT_W'(MEM_LATENCY);
      else if (r_state == ST_WAIT && r_latCnt != '0)
        r_latCnt <= r_latCnt - CNT_W'(1);
    end
  end

  // The memory strobe registers double as the address/data latch: they are
  // loaded on the grant edge, so the access appears on the bus during ISSUE.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_fetchAck  <= 1'b0;
      r_fetchData <= '0;
      r_dataAck   <= 1'b0;
      r_dataRdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_fetchAck <= 1'b0;
      r_dataAck  <= 1'b0;
      r_busy     <= (w_nextState != ST_IDLE);
      if (w_grant) begin
        r_memEn    <= 1'b1;
        r_memWe    <= w_selWe;
        r_memAddr  <= w_selAddr;
        r_memWdata <= w_selWdata;
      end
      if (w_lastBeat) begin
        if (r_owner == OWN_FETCH)
          r_fetchData <= i_mem_rdata;
        else if (!r_latWe)
          r_dataRdata <= i_mem_rdata;
        r_fetchAck <= (r_owner == OWN_FETCH);
        r_dataAck  <= (r_owner == OWN_DATA);
      end
    end
  end

  assign o_mem_en     = r_memEn;
  assign o_mem_we     = r_memWe;
  assign o_mem_addr   = r_memAddr;
  assign o_mem_wdata  = r_memWdata;
  assign o_fetch_ack  = r_fetchAck;
  assign o_fetch_data = r_fetchData;
  assign o_data_ack   = r_dataAck;
  assign o_data_rdata = r_dataRdata;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Directed bench for nano_mem_arbiter: one instance at MEM_LATENCY=1, one at 3,
// each backed by a simple synchronous memory model.
`timescale 1ns/1ps
module tb_nano_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       fReq1 = 1'b0, dReq1 = 1'b0, dWe1 = 1'b0;
  logic [7:0] fAddr1 = '0, dAddr1 = '0, dWdata1 = '0;
  logic       fAck1, dAck1, memEn1, memWe1, busy1;
  logic [7:0] fData1, dRdata1, memAddr1, memWdata1;
  logic [7:0] memRdata1 = '0;

  logic       fReq3 = 1'b0, dReq3 = 1'b0, dWe3 = 1'b0;
  logic [7:0] fAddr3 = '0, dAddr3 = '0, dWdata3 = '0;
  logic       fAck3, dAck3, memEn3, memWe3, busy3;
  logic [7:0] fData3, dRdata3, memAddr3, memWdata3, memRdata3;

  logic [7:0] mem1 [0:255] = '{0: 8'hA5, 1: 8'h5A, 2: 8'hE1, 3: 8'hC3, 4: 8'h4D, default: 8'h00};
  logic [7:0] mem3 [0:255] = '{8'h40: 8'h99, default: 8'h00};
  logic [7:0] pipe3 [0:2]  = '{default: 8'h00};

  int total = 0;
  int bad = 0;
  int protoErrs = 0;
  logic fPend1 = 1'b0, dPend1 = 1'b0, dPend3 = 1'b0;

  nano_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .i_clock(clock), .i_reset(reset),
    .i_fetch_req(fReq1), .i_fetch_addr(fAddr1), .o_fetch_ack(fAck1), .o_fetch_data(fData1),
    .i_data_req(dReq1), .i_data_we(dWe1), .i_data_addr(dAddr1), .i_data_wdata(dWdata1),
    .o_data_ack(dAck1), .o_data_rdata(dRdata1),
    .o_mem_en(memEn1), .o_mem_we(memWe1), .o_mem_addr(memAddr1), .o_mem_wdata(memWdata1),
    .i_mem_rdata(memRdata1), .o_busy(busy1)
  );

  nano_mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .i_clock(clock), .i_reset(reset),
    .i_fetch_req(fReq3), .i_fetch_addr(fAddr3), .o_fetch_ack(fAck3), .o_fetch_data(fData3),
    .i_data_req(dReq3), .i_data_we(dWe3), .i_data_addr(dAddr3), .i_data_wdata(dWdata3),
    .o_data_ack(dAck3), .o_data_rdata(dRdata3),
    .o_mem_en(memEn3), .o_mem_we(memWe3), .o_mem_addr(memAddr3), .o_mem_wdata(memWdata3),
    .i_mem_rdata(memRdata3), .o_busy(busy3)
  );

  // Read data is only valid exactly MEM_LATENCY cycles after the strobe, zero otherwise.
  always @(posedge clock) begin
    if (memEn1 && memWe1) mem1[memAddr1] <= memWdata1;
    memRdata1 <= memEn1 ? mem1[memAddr1] : 8'h00;
  end

  always @(posedge clock) begin
    if (memEn3 && memWe3) mem3[memAddr3] <= memWdata3;
    pipe3[0] <= memEn3 ? mem3[memAddr3] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign memRdata3 = pipe3[2];

  // A request must stay high from first assertion until its ack.
  always @(posedge clock) begin
    if (reset) begin
      fPend1 <= 1'b0;
      dPend1 <= 1'b0;
      dPend3 <= 1'b0;
    end else begin
      if ((fPend1 && !fReq1 && !fAck1) || (dPend1 && !dReq1 && !dAck1) ||
          (dPend3 && !dReq3 && !dAck3))
        protoErrs <= protoErrs + 1;
      fPend1 <= fAck1 ? 1'b0 : fReq1;
      dPend1 <= dAck1 ? 1'b0 : dReq1;
      dPend3 <= dAck3 ? 1'b0 : dReq3;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One data access; returns at the negedge of the following IDLE cycle.
  // lat = negedges from driving the request to seeing the ack (-1 on timeout).
  task automatic applyStimulus(input bit onDut3, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, output int lat);
    lat = -1;
    if (onDut3) begin
      dReq3 = 1'b1; dWe3 = we; dAddr3 = addr; dWdata3 = wdata;
    end else begin
      dReq1 = 1'b1; dWe1 = we; dAddr1 = addr; dWdata1 = wdata;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (onDut3 ? dAck3 : dAck1) begin
        lat = k;
        break;
      end
    end
    dReq1 = 1'b0;
    dReq3 = 1'b0;
    @(negedge clock);
  endtask

  // Hold both dut1 requests; record the grant order (1 = data) until nStop grants
  // have gone by, then let the in-flight fetch and the next data access finish.
  task automatic runBoth(input int nStop, input logic [7:0] fa, input logic [7:0] da,
                         input logic [7:0] expF, input logic [7:0] expD,
                         output logic [15:0] seq, output int n);
    seq = '0;
    n = 0;
    fReq1 = 1'b1; fAddr1 = fa;
    dReq1 = 1'b1; dWe1 = 1'b0; dAddr1 = da;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (memEn1) begin
        seq = {seq[14:0], (memAddr1 == da)};
        n++;
      end
      if (fAck1) begin
        checkOutput("both_fetch_data", 32'(fData1), 32'(expF));
        if (n >= nStop) fReq1 = 1'b0;
      end
      if (dAck1) begin
        checkOutput("both_data_rdata", 32'(dRdata1), 32'(expD));
        if (!fReq1) break;
      end
    end
    fReq1 = 1'b0;
    dReq1 = 1'b0;
    @(negedge clock);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    fReq1 = 1'b0; dReq1 = 1'b0; dReq3 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int acks;
    int strobes;
    logic [15:0] seq;
    int n;

    repeat (3) @(negedge clock);
    checkOutput("rst_busy1", 32'(busy1), 0);
    checkOutput("rst_mem_en1", 32'(memEn1), 0);
    checkOutput("rst_fetch_ack1", 32'(fAck1), 0);
    checkOutput("rst_fetch_data3", 32'(fData3), 0);
    checkOutput("rst_data_rdata3", 32'(dRdata3), 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the middle of a latency-3 store wait.
    $display("[TB] reset during WAIT of a store");
    dReq3 = 1'b1; dWe3 = 1'b1; dAddr3 = 8'h10; dWdata3 = 8'hEE;
    @(negedge clock);
    checkOutput("t1_issue_en", 32'(memEn3), 1);
    checkOutput("t1_issue_addr", 32'(memAddr3), 32'h10);
    checkOutput("t1_issue_wdata", 32'(memWdata3), 32'hEE);
    repeat (2) @(negedge clock);
    checkOutput("t1_busy_wait", 32'(busy3), 1);
    reset = 1'b1;
    dReq3 = 1'b0;
    #1;
    checkOutput("t1_rst_busy", 32'(busy3), 0);
    checkOutput("t1_rst_mem_en", 32'(memEn3), 0);
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      acks += int'(dAck3) + int'(fAck3);
      strobes += int'(memEn3);
    end
    checkOutput("t1_no_ack", 32'(acks), 0);
    checkOutput("t1_no_strobe", 32'(strobes), 0);

    $display("[TB] single fetch, latency 1");
    fReq1 = 1'b1; fAddr1 = 8'h00;
    @(negedge clock);
    checkOutput("t2_en_c1", 32'(memEn1), 1);
    checkOutput("t2_addr_c1", 32'(memAddr1), 0);
    checkOutput("t2_we_c1", 32'(memWe1), 0);
    checkOutput("t2_busy_c1", 32'(busy1), 1);
    @(negedge clock);
    checkOutput("t2_en_c2", 32'(memEn1), 0);
    checkOutput("t2_ack_c2", 32'(fAck1), 0);
    @(negedge clock);
    checkOutput("t2_ack_c3", 32'(fAck1), 1);
    checkOutput("t2_data_c3", 32'(fData1), 32'hA5);
    fReq1 = 1'b0;
    @(negedge clock);
    checkOutput("t2_ack_c4", 32'(fAck1), 0);
    checkOutput("t2_data_hold", 32'(fData1), 32'hA5);
    checkOutput("t2_idle_busy", 32'(busy1), 0);

    $display("[TB] simultaneous store and fetch");
    dReq1 = 1'b1; dWe1 = 1'b1; dAddr1 = 8'h20; dWdata1 = 8'h3C;
    fReq1 = 1'b1; fAddr1 = 8'h01;
    @(negedge clock);
    checkOutput("t3_st_en", 32'(memEn1), 1);
    checkOutput("t3_st_we", 32'(memWe1), 1);
    checkOutput("t3_st_addr", 32'(memAddr1), 32'h20);
    checkOutput("t3_st_wdata", 32'(memWdata1), 32'h3C);
    @(negedge clock);
    checkOutput("t3_we_idle", 32'(memWe1), 0);
    checkOutput("t3_wdata_idle", 32'(memWdata1), 0);
    @(negedge clock);
    checkOutput("t3_data_ack", 32'(dAck1), 1);
    checkOutput("t3_fetch_wait", 32'(fAck1), 0);
    checkOutput("t3_rdata_kept", 32'(dRdata1), 0);
    dReq1 = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("t3_f_en", 32'(memEn1), 1);
    checkOutput("t3_f_addr", 32'(memAddr1), 32'h01);
    checkOutput("t3_f_we", 32'(memWe1), 0);
    repeat (2) @(negedge clock);
    checkOutput("t3_f_ack", 32'(fAck1), 1);
    checkOutput("t3_f_data", 32'(fData1), 32'h5A);
    fReq1 = 1'b0;
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 8'h20, 8'h00, lat);
    checkOutput("t3_load_lat", 32'(lat), 3);
    checkOutput("t3_load_data", 32'(dRdata1), 32'h3C);

`ifdef NANO_ARB_ROUND_ROBIN_EN
    $display("[TB] round-robin alternation");
    applyReset();
    runBoth(4, 8'h03, 8'h04, 8'hC3, 8'h4D, seq, n);
    checkOutput("t6_grants", 32'(n), 5);
    checkOutput("t6_order", 32'(seq[4:0]), 32'b10101);
`else
    $display("[TB] starvation guard");
    runBoth(10, 8'h02, 8'h20, 8'hE1, 8'h3C, seq, n);
    checkOutput("t4_grants", 32'(n), 11);
    checkOutput("t4_order", 32'(seq[10:0]), 32'b11110111101);
`endif

    $display("[TB] latency-3 load around a store");
    applyStimulus(1'b1, 1'b0, 8'h40, 8'h00, lat);
    checkOutput("t5_load_lat", 32'(lat), 5);
    checkOutput("t5_load_data", 32'(dRdata3), 32'h99);
    applyStimulus(1'b1, 1'b1, 8'h41, 8'h55, lat);
    checkOutput("t5_store_lat", 32'(lat), 5);
    checkOutput("t5_rdata_after_store", 32'(dRdata3), 32'h99);
    applyStimulus(1'b1, 1'b0, 8'h41, 8'h00, lat);
    checkOutput("t5_reload_lat", 32'(lat), 5);
    checkOutput("t5_reload_data", 32'(dRdata3), 32'h55);

    @(negedge clock);
    checkOutput("protocol", 32'(protoErrs), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
